// File: rtl/shumezues_sekuencial_pkg.sv
// Shared definitions for the 24-bit CPU datapath: operand width, iteration
// count and the multiplier controller state encoding.
package cpu24_pkg;

  localparam int GJERESIA = 24;
  localparam int HAPA     = 24;
  localparam int CNT_W    = 5;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_LLOGARIT   = 2'd1;
  localparam logic [1:0] ST_PERFUNDUAR = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    LLOGARIT   = ST_LLOGARIT,
    PERFUNDUAR = ST_PERFUNDUAR
  } gjendja_e;

  // True on the iteration whose result completes the product.
  function automatic logic hapi_fundit(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(HAPA - 1);
  endfunction

endpackage

// File: rtl/shumezues_sekuencial_mbledhesi.sv
// 24-bit ripple-carry adder shared by the datapath; one full adder per bit,
// each stage carrying into the next.
module Mbledhesi24Bitesh
  import cpu24_pkg::*;
(
  input  logic [GJERESIA-1:0] A,
  input  logic [GJERESIA-1:0] B,
  input  logic                CIN,
  output logic [GJERESIA-1:0] Shuma,
  output logic                CarryOut
);

  for (genvar i = 0; i < GJERESIA; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = CIN;
    end else begin : g_rest
      assign ci = g_bit[i-1].co;
    end
    assign Shuma[i] = A[i] ^ B[i] ^ ci;
    assign co       = (A[i] & B[i]) | (ci & (A[i] ^ B[i]));
  end

  assign CarryOut = g_bit[GJERESIA-1].co;

endmodule

// File: rtl/shumezues_sekuencial.sv
// Sequential 24x24 unsigned shift-and-add multiplier; one adder step per
// clock, controlled by a Start/Ready/Done handshake with synchronous abort.
module shumezues_sekuencial
  import cpu24_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Anulo,
  input  logic [GJERESIA-1:0]   Shumezuesi,
  input  logic [GJERESIA-1:0]   Shumezori,
  output logic                  Ready,
  output logic                  Done,
  output logic [2*GJERESIA-1:0] Produkti
);

  gjendja_e                state_q, state_d;
  logic [GJERESIA-1:0]     m_q, m_d;
  logic [GJERESIA-1:0]     hi_q, hi_d;
  logic [GJERESIA-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*GJERESIA-1:0]   prod_q, prod_d;

  logic [GJERESIA-1:0]     b_mask;
  logic [GJERESIA-1:0]     shuma;
  logic                    carry_out;
  logic [GJERESIA-1:0]     step_hi;
  logic [GJERESIA-1:0]     step_lo;

  // Add M only when the current multiplier bit is set; the carry becomes
  // the new top bit of Hi and the sum's LSB shifts down into Lo.
  assign b_mask = lo_q[0] ? m_q : '0;

  Mbledhesi24Bitesh u_mbledhesi (
    .A        (hi_q),
    .B        (b_mask),
    .CIN      (1'b0),
    .Shuma    (shuma),
    .CarryOut (carry_out)
  );

  assign step_hi = {carry_out, shuma[GJERESIA-1:1]};
  assign step_lo = {shuma[0], lo_q[GJERESIA-1:1]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          m_d     = Shumezuesi;
          hi_d    = '0;
          lo_d    = Shumezori;
          cnt_d   = '0;
          state_d = LLOGARIT;
        end
      end
      LLOGARIT: begin
        // Abort wins over the final step: no write to Produkti, no Done.
        if (Anulo) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (hapi_fundit(cnt_q)) begin
            prod_d  = {step_hi, step_lo};
            state_d = PERFUNDUAR;
          end
        end
      end
      PERFUNDUAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign Ready    = (state_q == IDLE);
  assign Done     = (state_q == PERFUNDUAR);
  assign Produkti = prod_q;

endmodule

// File: tb/tb_shumezues_sekuencial.sv
// Scoreboard bench for the sequential multiplier: the driver pushes the
// arithmetic product and accept cycle, a monitor pops them on every Done.
module tb_shumezues_sekuencial;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Anulo = 1'b0;
  logic [23:0] Shumezuesi = '0;
  logic [23:0] Shumezori = '0;
  logic        Ready;
  logic        Done;
  logic [47:0] Produkti;

  shumezues_sekuencial dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Anulo      (Anulo),
    .Shumezuesi (Shumezuesi),
    .Shumezori  (Shumezori),
    .Ready      (Ready),
    .Done       (Done),
    .Produkti   (Produkti)
  );

  always #5 Clock = ~Clock;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [47:0] exp_q[$];
  int          acc_q[$];
  logic [47:0] last_prod = '0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding request.
  always @(negedge Clock) begin
    if (Reset_n && Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 48'd1, 48'd0);
      end else begin
        logic [47:0] e;
        int          k;
        e = exp_q.pop_front();
        k = acc_q.pop_front();
        chk("product", Produkti, e);
        chk("done_latency", 48'(cyc - k), 48'd24);
        chk("ready_low_at_done", {47'd0, Ready}, 48'd0);
      end
    end
  end

  task automatic issue(input logic [23:0] a, input logic [23:0] b,
                       input bit track, input bit with_abort);
    int n;
    n = 0;
    @(negedge Clock);
    while (!Ready && n < 60) begin
      @(negedge Clock);
      n++;
    end
    if (!Ready) begin
      chk("ready_timeout", 48'd0, 48'd1);
      return;
    end
    Shumezuesi = a;
    Shumezori  = b;
    Start      = 1'b1;
    Anulo      = with_abort;
    @(posedge Clock);
    #1;
    Start      = 1'b0;
    Anulo      = 1'b0;
    Shumezuesi = $urandom;
    Shumezori  = $urandom;
    if (track) begin
      exp_q.push_back(48'(a) * 48'(b));
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_done(input int d0);
    int busy_err;
    int n;
    busy_err = 0;
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge Clock);
      #2;
      if (done_cnt == d0 && Ready) busy_err++;
      n++;
    end
    chk("done_timeout", {47'd0, done_cnt == d0}, 48'd0);
    chk("ready_busy", 48'(busy_err), 48'd0);
  endtask

  task automatic run(input logic [23:0] a, input logic [23:0] b, input bit with_abort);
    int d0;
    d0 = done_cnt;
    issue(a, b, 1'b1, with_abort);
    wait_done(d0);
    last_prod = 48'(a) * 48'(b);
    @(negedge Clock);
    #2;
    chk("ready_after_done", {47'd0, Ready}, 48'd1);
    chk("done_one_cycle", {47'd0, Done}, 48'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [23:0] a;
    logic [23:0] b;

    repeat (3) @(negedge Clock);
    chk("reset_ready", {47'd0, Ready}, 48'd1);
    chk("reset_done", {47'd0, Done}, 48'd0);
    chk("reset_prod", Produkti, 48'd0);
    Reset_n = 1'b1;

    run(24'd3, 24'd5, 1'b0);
    repeat (4) @(negedge Clock);
    chk("prod_hold", Produkti, 48'h00000000000F);

    run(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    chk("carry_full", Produkti, 48'hFFFFFE000001);
    run(24'h800000, 24'h000002, 1'b0);
    chk("carry_top", Produkti, 48'h000001000000);
    run(24'h000000, 24'h123456, 1'b0);
    chk("zero_a", Produkti, 48'd0);
    run(24'h123456, 24'h000000, 1'b0);
    chk("zero_b", Produkti, 48'd0);

    // Start and Anulo together while idle: the request is taken.
    run(24'd9, 24'd11, 1'b1);
    chk("start_with_anulo", Produkti, 48'd99);

    // A second Start mid-run must be dropped, not queued.
    d0 = done_cnt;
    issue(24'd3, 24'd5, 1'b1, 1'b0);
    repeat (5) @(negedge Clock);
    Shumezuesi = 24'd7;
    Shumezori  = 24'd7;
    Start      = 1'b1;
    @(negedge Clock);
    Start      = 1'b0;
    wait_done(d0);
    repeat (30) @(negedge Clock);
    chk("busy_ignored_prod", Produkti, 48'd15);
    chk("busy_ignored_ready", {47'd0, Ready}, 48'd1);
    chk("busy_single_done", 48'(done_cnt - d0), 48'd1);

    // Abort in step 10 leaves the earlier product in place.
    d0 = done_cnt;
    issue(24'd9, 24'd9, 1'b0, 1'b0);
    repeat (9) @(posedge Clock);
    #1 Anulo = 1'b1;
    @(posedge Clock);
    #1 Anulo = 1'b0;
    @(negedge Clock);
    chk("abort_ready", {47'd0, Ready}, 48'd1);
    chk("abort_prod", Produkti, 48'd15);
    repeat (30) @(negedge Clock);
    chk("abort_no_done", 48'(done_cnt - d0), 48'd0);
    chk("abort_prod_later", Produkti, 48'd15);
    run(24'd2, 24'd2, 1'b0);
    chk("after_abort", Produkti, 48'd4);

    // Anulo outside a run has no effect.
    Anulo = 1'b1;
    repeat (3) @(negedge Clock);
    Anulo = 1'b0;
    chk("anulo_idle_prod", Produkti, 48'd4);

    // Asynchronous reset in step 12.
    issue(24'd5, 24'd5, 1'b0, 1'b0);
    repeat (12) @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_ready", {47'd0, Ready}, 48'd1);
    chk("async_rst_done", {47'd0, Done}, 48'd0);
    chk("async_rst_prod", Produkti, 48'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    run(24'd6, 24'd7, 1'b0);
    chk("after_reset", Produkti, 48'd42);

    for (int i = 0; i < 20; i++) begin
      a = 24'($urandom);
      b = 24'($urandom);
      if (i % 7 == 3) a = 24'hFFFFFF;
      if (i % 5 == 4) b = 24'($urandom_range(0, 3));
      run(a, b, 1'b0);
      chk("rand_hold", Produkti, last_prod);
    end

    chk("scoreboard_empty", 48'(exp_q.size()), 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
